// File: rtl/subparser_arg_sequencer.sv
// rtl/subparser_arg_sequencer.sv - sequences one argument subparser through N parses
// and lends it the shared byte reader only while a parse is in flight.
module subparser_arg_sequencer #(
  parameter int MAX_ARGS  = 4,
  parameter int ARG_WIDTH = 16,
  parameter int CNT_WIDTH = $clog2(MAX_ARGS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger,
  input  logic [CNT_WIDTH-1:0]          num_args,
  output logic                          rdy,
  output logic                          done,
  output logic                          success,
  output logic                          newline,
  output logic [CNT_WIDTH-1:0]          args_parsed,
  output logic [MAX_ARGS*ARG_WIDTH-1:0] args,
  output logic                          arg_trigger,
  input  logic                          arg_rdy,
  input  logic                          arg_done,
  input  logic                          arg_success,
  input  logic                          arg_newline,
  input  logic [ARG_WIDTH-1:0]          arg_value,
  input  logic                          arg_rd_trigger,
  output logic                          arg_rd_done,
  output logic                          arg_rd_rdy,
  output logic                          arg_is_empty,
  output logic                          rd_trigger,
  input  logic                          rd_done,
  input  logic                          rd_rdy,
  input  logic                          is_empty
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_ARGS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    TRIG      = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t state, state_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] next_idx;
  logic                 last_arg;

  assign next_idx = args_parsed + CNT_WIDTH'(1);
  assign last_arg = (next_idx == count);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trigger) begin
          if (num_args == '0 || num_args > MAX_CNT) state_next = FINISH;
          else                                     state_next = WAIT_RDY;
        end
      end
      WAIT_RDY:  if (arg_rdy) state_next = TRIG;
      TRIG:      state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (arg_done) begin
          // Only a clean, non-final, non-newline parse loops back for more.
          if (arg_success && !last_arg && !arg_newline) state_next = WAIT_RDY;
          else                                          state_next = FINISH;
        end
      end
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    rdy          = (state == IDLE);
    done         = (state == FINISH);
    arg_trigger  = (state == TRIG);
    rd_trigger   = 1'b0;
    arg_rd_done  = 1'b0;
    arg_rd_rdy   = 1'b0;
    arg_is_empty = 1'b0;
    if (state == WAIT_DONE) begin
      rd_trigger   = arg_rd_trigger;
      arg_rd_done  = rd_done;
      arg_rd_rdy   = rd_rdy;
      arg_is_empty = is_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      args_parsed <= '0;
      success     <= 1'b0;
      newline     <= 1'b0;
      args        <= '0;
    end else if (state == IDLE && trigger) begin
      count       <= num_args;
      args_parsed <= '0;
      success     <= (num_args == '0);
      newline     <= 1'b0;
      args        <= '0;
    end else if (state == WAIT_DONE && arg_done) begin
      if (arg_success) begin
        for (int k = 0; k < MAX_ARGS; k++) begin
          if (args_parsed == k[CNT_WIDTH-1:0]) args[k*ARG_WIDTH +: ARG_WIDTH] <= arg_value;
        end
        args_parsed <= next_idx;
        if (last_arg) begin
          success <= 1'b1;
          newline <= arg_newline;
        end else if (arg_newline) begin
          success <= 1'b0;
          newline <= 1'b1;
        end
      end else begin
        success <= 1'b0;
        newline <= arg_newline;
      end
    end
  end

endmodule

// File: tb/tb_subparser_arg_sequencer.sv
// tb/tb_subparser_arg_sequencer.sv - directed-vector bench for subparser_arg_sequencer.
module tb_subparser_arg_sequencer;
  localparam int MA = 4;
  localparam int AW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trigger = 1'b0;
  logic [CW-1:0] num_args = '0;
  logic          rdy, done, success, newline;
  logic [CW-1:0] args_parsed;
  logic [MA*AW-1:0] args;
  logic          arg_trigger;
  logic          arg_rdy = 1'b1;
  logic          arg_done = 1'b0;
  logic          arg_success = 1'b0;
  logic          arg_newline = 1'b0;
  logic [AW-1:0] arg_value = '0;
  logic          arg_rd_trigger = 1'b0;
  logic          arg_rd_done, arg_rd_rdy, arg_is_empty, rd_trigger;
  logic          rd_done = 1'b0;
  logic          rd_rdy = 1'b0;
  logic          is_empty = 1'b0;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int trig_base, done_base;

  subparser_arg_sequencer #(.MAX_ARGS(MA), .ARG_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .num_args(num_args),
    .rdy(rdy), .done(done), .success(success), .newline(newline),
    .args_parsed(args_parsed), .args(args), .arg_trigger(arg_trigger),
    .arg_rdy(arg_rdy), .arg_done(arg_done), .arg_success(arg_success),
    .arg_newline(arg_newline), .arg_value(arg_value),
    .arg_rd_trigger(arg_rd_trigger), .arg_rd_done(arg_rd_done),
    .arg_rd_rdy(arg_rd_rdy), .arg_is_empty(arg_is_empty),
    .rd_trigger(rd_trigger), .rd_done(rd_done), .rd_rdy(rd_rdy),
    .is_empty(is_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arg_trigger) trig_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [CW-1:0] n);
    trigger  = 1'b1;
    num_args = n;
    step();
    trigger  = 1'b0;
  endtask

  task automatic wait_trig();
    int n = 0;
    while (!arg_trigger && n < 20) begin
      step();
      n++;
    end
    check("arg_trigger_seen", arg_trigger, 1);
  endtask

  task automatic give_arg(input logic [AW-1:0] v, input logic s, input logic nl);
    wait_trig();
    step();
    arg_done    = 1'b1;
    arg_value   = v;
    arg_success = s;
    arg_newline = nl;
    step();
    arg_done    = 1'b0;
    arg_value   = '0;
    arg_success = 1'b0;
    arg_newline = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    arg_rd_trigger = 1'b1;
    step();
    check("reset_rdy", rdy, 1);
    check("reset_done", done, 0);
    check("idle_rd_trigger", rd_trigger, 0);
    check("reset_args", args, 0);
    check("reset_args_parsed", args_parsed, 0);
    check("reset_success", success, 0);
    arg_rd_trigger = 1'b0;

    // Three clean args, newline on the last.
    trig_base = trig_cnt;
    done_base = done_cnt;
    start(3);
    check("lat_t1_no_trig", arg_trigger, 0);
    check("lat_t1_not_rdy", rdy, 0);
    step();
    check("lat_t2_trig", arg_trigger, 1);
    give_arg(16'd10, 1'b1, 1'b0);
    check("between_args_no_trig", arg_trigger, 0);
    step();
    check("next_trig_2_cycles", arg_trigger, 1);
    give_arg(16'd20, 1'b1, 1'b0);
    give_arg(16'd30, 1'b1, 1'b1);
    check("t3_done", done, 1);
    check("t3_success", success, 1);
    check("t3_newline", newline, 1);
    check("t3_args_parsed", args_parsed, 3);
    check("t3_args", args, {16'd0, 16'd30, 16'd20, 16'd10});
    step();
    check("t3_rdy_after_done", rdy, 1);
    check("t3_done_low", done, 0);
    check("t3_trig_count", trig_cnt - trig_base, 3);
    check("t3_done_count", done_cnt - done_base, 1);

    // Premature newline on the first of two.
    trig_base = trig_cnt;
    start(2);
    give_arg(16'd100, 1'b1, 1'b1);
    check("nl_done", done, 1);
    check("nl_success", success, 0);
    check("nl_newline", newline, 1);
    check("nl_args_parsed", args_parsed, 1);
    check("nl_args", args, 64'h64);
    step();
    check("nl_trig_count", trig_cnt - trig_base, 1);

    // Second argument fails.
    start(2);
    give_arg(16'd5, 1'b1, 1'b0);
    give_arg(16'd7, 1'b0, 1'b0);
    check("fail_done", done, 1);
    check("fail_success", success, 0);
    check("fail_newline", newline, 0);
    check("fail_args_parsed", args_parsed, 1);
    check("fail_args", args, 64'h5);
    step();

    // Reader routing, trigger-while-busy and reset mid-sequence.
    start(1);
    wait_trig();
    rd_done = 1'b1; rd_rdy = 1'b1; is_empty = 1'b1; arg_rd_trigger = 1'b1;
    #1;
    check("trig_mirrors", {rd_trigger, arg_rd_done, arg_rd_rdy, arg_is_empty}, 4'b0000);
    step();
    for (int p = 0; p < 16; p++) begin
      {arg_rd_trigger, rd_done, rd_rdy, is_empty} = 4'(p);
      #1;
      check("wd_mirrors", {rd_trigger, arg_rd_done, arg_rd_rdy, arg_is_empty}, 64'(p));
    end
    trigger  = 1'b1;
    num_args = 3'd0;
    step();
    trigger  = 1'b0;
    check("busy_trig_rdy", rdy, 0);
    check("busy_trig_done", done, 0);
    {arg_rd_trigger, rd_done, rd_rdy, is_empty} = 4'b1111;
    #1;
    check("busy_trig_still_wd", {rd_trigger, arg_rd_done, arg_rd_rdy, arg_is_empty}, 4'b1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_rdy", rdy, 1);
    check("mid_reset_done", done, 0);
    check("mid_reset_arg_trigger", arg_trigger, 0);
    check("mid_reset_mirrors", {rd_trigger, arg_rd_done, arg_rd_rdy, arg_is_empty}, 4'b0000);
    check("mid_reset_args", args, 0);
    check("mid_reset_parsed", args_parsed, 0);
    {arg_rd_trigger, rd_done, rd_rdy, is_empty} = 4'b0000;

    // Zero and too-many argument counts.
    trig_base = trig_cnt;
    start(0);
    check("zero_done", done, 1);
    check("zero_success", success, 1);
    check("zero_parsed", args_parsed, 0);
    step();
    check("zero_rdy", rdy, 1);
    check("zero_no_trig", trig_cnt - trig_base, 0);
    start(5);
    check("over_done", done, 1);
    check("over_success", success, 0);
    step();
    check("over_rdy", rdy, 1);
    check("over_no_trig", trig_cnt - trig_base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/subparser_arg_sequencer.md
Name: subparser_arg_sequencer

Overview:
- Controller that sequences one shared argument subparser through N consecutive argument parses for a single command line, and latches each parsed value into a packed result vector.
- Owns the byte-reader handshake and lends it to the argument subparser only while that subparser is active.
- Sits between a command-level parser (e.g. a G-code command parser) and its argument subparser and reader.

Parameters:
- MAX_ARGS, 4, maximum arguments per command; minimum 1.
- ARG_WIDTH, 16, width of one parsed argument value.
- CNT_WIDTH, $clog2(MAX_ARGS+1), width of the argument count and index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  start sequence; honoured only while rdy=1.
- num_args  in  CNT_WIDTH  number of arguments to parse; sampled with trigger.
- rdy  out  1  idle, accepting trigger.
- done  out  1  one-cycle pulse: sequence finished.
- success  out  1  result status, valid from done until next accepted trigger.
- newline  out  1  newline was seen, valid with success.
- args_parsed  out  CNT_WIDTH  count of successfully parsed arguments.
- args  out  MAX_ARGS*ARG_WIDTH  arg i stored in bits [i*ARG_WIDTH +: ARG_WIDTH].
- arg_trigger  out  1  one-cycle trigger to argument subparser.
- arg_rdy  in  1  argument subparser ready.
- arg_done  in  1  argument subparser done pulse.
- arg_success  in  1  argument parse ok, sampled with arg_done.
- arg_newline  in  1  argument hit newline, sampled with arg_done.
- arg_value  in  ARG_WIDTH  parsed value, sampled with arg_done.
- arg_rd_trigger  in  1  read request from argument subparser.
- arg_rd_done  out  1  reader done, forwarded to the subparser.
- arg_rd_rdy  out  1  reader ready, forwarded to the subparser.
- arg_is_empty  out  1  reader empty, forwarded to the subparser.
- rd_trigger  out  1  read request to the shared reader.
- rd_done  in  1  reader done.
- rd_rdy  in  1  reader ready.
- is_empty  in  1  reader has nothing to read.

Behaviour:
- States:
  - IDLE: rdy=1.
  - WAIT_RDY: wait for arg_rdy.
  - TRIG: arg_trigger=1 for exactly one cycle.
  - WAIT_DONE: wait for arg_done.
  - FINISH: done=1 for one cycle, then return to IDLE.
- Reset (synchronous; applies from any state, including mid-sequence): state IDLE; rdy=1; done, success, newline, arg_trigger, rd_trigger, arg_rd_done, arg_rd_rdy, arg_is_empty = 0; args_parsed=0; args=0.
- IDLE with trigger=1:
  - Latch num_args; clear args_parsed, success, newline and args.
  - num_args=0 -> FINISH next cycle, success=1.
  - num_args>MAX_ARGS -> FINISH next cycle, success=0.
  - Otherwise -> WAIT_RDY.
- trigger while rdy=0 is ignored.
- WAIT_RDY: arg_rdy=1 -> TRIG next cycle. Stays indefinitely if arg_rdy=0; there is no timeout.
- TRIG: arg_trigger=1 this cycle only, then -> WAIT_DONE.
- Reader routing (combinational):
  - In WAIT_DONE only: rd_trigger=arg_rd_trigger, arg_rd_done=rd_done, arg_rd_rdy=rd_rdy, arg_is_empty=is_empty.
  - In all other states: rd_trigger=0, arg_rd_done=0, arg_rd_rdy=0, arg_is_empty=0.
- WAIT_DONE with arg_done=1, with i = args_parsed:
  - arg_success=1: store arg_value into slot i; args_parsed <= i+1.
    - i+1 == latched count -> FINISH with success=1, newline=arg_newline.
    - Otherwise, arg_newline=1 -> FINISH with success=0, newline=1 (premature end of line).
    - Otherwise -> WAIT_RDY for the next argument.
  - arg_success=0: -> FINISH with success=0, newline=arg_newline; slot i unchanged; args_parsed unchanged.
- Latency with arg_rdy held 1: trigger at cycle T -> arg_trigger at T+2 (T+1 WAIT_RDY, T+2 TRIG). After the arg_done of a non-final argument, the next arg_trigger follows 2 cycles later. After the final arg_done, done pulses 1 cycle later. rdy returns to 1 the cycle after done.
- arg_done outside WAIT_DONE is ignored.
- success, newline, args_parsed and args hold their values until the next accepted trigger.

Test Plan:
- Reset, then idle -> rdy=1, done=0, rd_trigger=0, args=0; driving arg_rd_trigger=1 in IDLE keeps rd_trigger=0.
- num_args=3, MAX_ARGS=4; subparser returns 10, 20, 30, each with success=1, newline on the 3rd only -> 3 arg_trigger pulses; done pulses once 1 cycle after the 3rd arg_done; success=1, newline=1, args_parsed=3; args slots = 10, 20, 30, 0.
- num_args=2; 1st arg succeeds with newline=1 -> done with success=0, newline=1, args_parsed=1; only 1 arg_trigger issued.
- num_args=2; 2nd arg returns arg_success=0 -> success=0, args_parsed=1, slot1=0.
- During WAIT_DONE toggle rd_done, rd_rdy, is_empty and arg_rd_trigger -> each appears on its mirror port in the same cycle; in IDLE/TRIG all mirrors=0.
- Edge cases:
  - num_args=0 -> done 1 cycle after trigger, success=1, no arg_trigger.
  - num_args=5 -> done, success=0.
  - trigger during WAIT_DONE is ignored.
  - reset asserted during WAIT_DONE -> IDLE next cycle, all outputs at reset values.
